go_board_led_pattern: RTL and testbench

- Top-level LED pattern controller for the Nandland Go board.
- LED1 is a steady "alive" indicator.
- LED2..LED4 show one of four tick-driven patterns.
- Two debounced push-buttons control the block: SW1 cycles the pattern mode, SW2 toggles pause.

---
 rtl/go_board_led_pattern.sv | 183 ++++++++++++++++++
 tb/tb_go_board_led_pattern.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/go_board_led_pattern.sv
// Go board LED controller: LED1 alive, LED2..LED4 show one of four tick-driven patterns; SW1 = mode, SW2 = pause.
// Latency: LEDs are registers; a button acts 2 sync edges + DEBOUNCE_CYCLES edges after its pin settles high.
// Backpressure: none (free-running); `GO_BOARD_PWM_DIM_EN adds PWM dimming of LED2..LED4.
module go_board_led_pattern #(
  parameter int unsigned TICK_DIV        = 2500000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PWM_BITS        = 4,
  parameter int unsigned DIM_DUTY        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic SW1,
  input  logic SW2,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------- tick
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  // Tick pulses on the last count of each period and the counter wraps.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // ------------------------------------------------------------- buttons
  // Bit 0 is SW1 (mode), bit 1 is SW2 (pause).
  logic [1:0]           btn_raw;
  logic [1:0]           meta_q, sync_q;
  logic [1:0]           db_q, db_d;
  logic [1:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]           press;

  assign btn_raw = {SW2, SW1};

  // Count consecutive cycles the synchronized level disagrees with the
  // accepted level; accept it on the DEBOUNCE_CYCLES-th such cycle.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press    = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync_q[b] != db_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          db_d[b]  = sync_q[b];
          press[b] = sync_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
        end
      end
    end
  end

  // Synchronizer, debounce and tick state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      db_q       <= '0;
      db_cnt_q   <= '0;
      tick_cnt_q <= '0;
    end else begin
      meta_q     <= btn_raw;
      sync_q     <= meta_q;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // ------------------------------------------------------------- pattern
  logic [1:0] mode_q, mode_d;
  logic       pause_q, pause_d;
  logic       dir_up_q, dir_up_d;
  logic [2:0] pattern_q, pattern_d;

  function automatic logic [2:0] mode_init(input logic [1:0] m);
    return (m[0]) ? 3'b001 : 3'b000;
  endfunction

  // Mode change takes priority over a coincident tick; pause only gates ticks.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    pause_d   = pause_q ^ press[1];
    if (press[0]) begin
      mode_d    = mode_q + 2'd1;
      pattern_d = mode_init(mode_d);
      dir_up_d  = 1'b1;
    end else if (tick && !pause_q) begin
      case (mode_q)
        2'd0: pattern_d = pattern_q + 3'd1;
        2'd1: pattern_d = {pattern_q[1:0], pattern_q[2]};
        2'd2: pattern_d = ~pattern_q;
        default: begin
          // Ping-pong: bounce off either end without repeating it.
          if (dir_up_q) begin
            if (pattern_q[2]) begin
              pattern_d = 3'b010;
              dir_up_d  = 1'b0;
            end else begin
              pattern_d = {pattern_q[1:0], 1'b0};
            end
          end else begin
            if (pattern_q[0]) begin
              pattern_d = 3'b010;
              dir_up_d  = 1'b1;
            end else begin
              pattern_d = {1'b0, pattern_q[2:1]};
            end
          end
        end
      endcase
    end
  end

  // Mode, pause, direction and pattern registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= '0;
      pause_q   <= 1'b0;
      dir_up_q  <= 1'b1;
      pattern_q <= '0;
    end else begin
      mode_q    <= mode_d;
      pause_q   <= pause_d;
      dir_up_q  <= dir_up_d;
      pattern_q <= pattern_d;
    end
  end

  // ------------------------------------------------------------- outputs
  logic alive_q;

  // LED1 comes on at the first edge after reset and stays on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

  assign LED1 = alive_q;

`ifdef GO_BOARD_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_on;
  logic [2:0]          led_dim_q;

  // Gate against next-state values so dimmed LEDs stay aligned with the pattern.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (32'(pwm_cnt_d) < DIM_DUTY);
  end

  // Free-running PWM counter and dimmed LED register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      led_dim_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      led_dim_q <= pattern_d & {3{pwm_on}};
    end
  end

  assign {LED4, LED3, LED2} = led_dim_q;
`else
  assign {LED4, LED3, LED2} = pattern_q;
`endif

endmodule

// File: tb/tb_go_board_led_pattern.sv
// Bench for go_board_led_pattern with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// A step-count model predicts every cycle's LEDs; directed checkpoints pin literal values.
// Inputs change 1 time unit after the falling edge; outputs are compared on the falling edge.
module tb_go_board_led_pattern;

  localparam int TICK_DIV = 4;
  localparam int DB       = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic SW1 = 1'b0;
  logic SW2 = 1'b0;
  logic LED1, LED2, LED3, LED4;
  logic [3:0] leds;

  int n_chk  = 0;
  int n_fail = 0;

  go_board_led_pattern #(
    .TICK_DIV(TICK_DIV),
    .DEBOUNCE_CYCLES(DB),
    .PWM_BITS(4),
    .DIM_DUTY(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .SW1(SW1),
    .SW2(SW2),
    .LED1(LED1),
    .LED2(LED2),
    .LED3(LED3),
    .LED4(LED4)
  );

  always #5 clk = ~clk;

  assign leds = {LED4, LED3, LED2, LED1};

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: LED4..LED1=%b expected %b", name, $time, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The pattern is a pure function of the mode and the number of steps
  // taken since that mode was entered.
  int m_edges, m_mode, m_phase;
  bit m_pause, m_alive;
  bit [1:0] h1, h2, m_db;
  int run [2];

  function automatic logic [2:0] model_pattern(input int mode, input int phase);
    case (mode)
      0: return 3'(phase % 8);
      1: return 3'(1 << (phase % 3));
      2: return (phase % 2 == 1) ? 3'b111 : 3'b000;
      default: begin
        case (phase % 4)
          0: return 3'b001;
          1: return 3'b010;
          2: return 3'b100;
          default: return 3'b010;
        endcase
      end
    endcase
  endfunction

  task automatic reset_model();
    m_edges = 0; m_mode = 0; m_phase = 0; m_pause = 0; m_alive = 0;
    h1 = '0; h2 = '0; m_db = '0; run[0] = 0; run[1] = 0;
  endtask

  task automatic step_model(input bit s1, input bit s2);
    bit [1:0] raw, pr;
    bit sv, tick, adv;
    raw = {s2, s1};
    pr  = '0;
    for (int b = 0; b < 2; b++) begin
      sv = h2[b];                      // level sampled two edges ago
      h2[b] = h1[b];
      h1[b] = raw[b];
      if (sv != m_db[b]) begin
        run[b]++;
        if (run[b] == DB) begin
          m_db[b] = sv;
          run[b]  = 0;
          pr[b]   = sv;
        end
      end else begin
        run[b] = 0;
      end
    end
    tick = (m_edges % TICK_DIV) == TICK_DIV - 1;
    m_edges++;
    adv = tick && !m_pause && !pr[0];
    if (pr[0]) begin
      m_mode  = (m_mode + 1) % 4;
      m_phase = 0;
    end else if (adv) begin
      m_phase++;
    end
    if (pr[1]) m_pause = !m_pause;
    m_alive = 1;
  endtask

  // Per-cycle comparison against the model.
  initial begin
    reset_model();
    forever begin
      @(negedge clk);
      if (rst) reset_model();
      else step_model(SW1, SW2);
      check("cycle", leds, {model_pattern(m_mode, m_phase), m_alive});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ------------------------------------------------------------ stimulus
  // Edge numbers e<k> count rising edges after the first reset release.
  initial begin
    rst = 1'b1; SW1 = 1'b0; SW2 = 1'b0;
    step(5);
    check("in_reset", leds, 4'b0000);
    rst = 1'b0;
    step(1);                                  // e0
    check("alive_first_edge", leds, 4'b0001);
    step(3);                                  // e3: first tick
    check("mode0_first_tick", leds, 4'b0011);
    step(36);                                 // e39: 10 ticks
    check("mode0_40_cycles", leds, 4'b0101);

    // Two-cycle glitch on SW1 must be rejected.
    SW1 = 1'b1; step(2); SW1 = 1'b0;          // e41
    step(8);                                  // e49
    check("glitch_ignored", leds, 4'b1001);

    // Long SW1 press: mode1, loaded with 001 at e54.
    SW1 = 1'b1; step(5);                      // e54
    check("mode1_enter", leds, 4'b0011);
    step(5);                                  // e59
    SW1 = 1'b0;
    check("mode1_100", leds, 4'b1001);
    step(4);                                  // e63
    check("mode1_wrap_001", leds, 4'b0011);

    // Pause in mode1 while showing 010.
    step(1);                                  // e64
    SW2 = 1'b1; step(5); SW2 = 1'b0;          // e69: pause accepted
    check("pause_at_010", leds, 4'b0101);
    step(18);                                 // e87: 5 ticks held
    check("pause_hold", leds, 4'b0101);
    SW2 = 1'b1; step(5); SW2 = 1'b0;          // e92: unpause
    check("unpause_no_jump", leds, 4'b0101);
    step(3);                                  // e95: tick
    check("resume_100", leds, 4'b1001);

    // Mode2 then mode3.
    SW1 = 1'b1; step(5); SW1 = 1'b0;          // e100
    check("mode2_enter", leds, 4'b0001);
    step(3);                                  // e103
    check("mode2_blink", leds, 4'b1111);
    step(2);                                  // e105
    SW1 = 1'b1; step(5); SW1 = 1'b0;          // e110
    check("mode3_enter", leds, 4'b0011);
    step(1);  check("pp_010a", leds, 4'b0101); // e111
    step(4);  check("pp_100",  leds, 4'b1001); // e115
    step(4);  check("pp_010b", leds, 4'b0101); // e119
    step(4);  check("pp_001",  leds, 4'b0011); // e123
    step(4);  check("pp_010c", leds, 4'b0101); // e127

    // Fourth press lands exactly on a tick edge (e135): mode0, 000.
    step(3);                                  // e130
    SW1 = 1'b1; step(5); SW1 = 1'b0;          // e135
    check("wrap_mode0_tick_collide", leds, 4'b0001);
    step(4);                                  // e139
    check("mode0_after_wrap", leds, 4'b0011);

    // Go to mode2 again, then reset asynchronously.
    step(1);                                  // e140
    SW1 = 1'b1; step(5); SW1 = 1'b0;          // e145: mode1
    step(5);                                  // e150
    SW1 = 1'b1; step(5); SW1 = 1'b0;          // e155: mode2
    check("mode2_again", leds, 4'b0001);
    step(4);                                  // e159
    check("mode2_again_blink", leds, 4'b1111);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_immediate", leds, 4'b0000);
    step(3);
    rst = 1'b0;
    step(1);
    check("post_reset_alive", leds, 4'b0001);
    step(3);
    check("post_reset_mode0", leds, 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
